// File: rtl/serial_perceptron.sv
// Bit-serial perceptron: accumulates one weighted binary input per cycle, then thresholds sum+bias.
// Define PERCEPTRON_TRAIN_EN to add the target port and a one-cycle perceptron weight update on misclassification.
module serial_perceptron #(
    parameter int N_IN  = 16,
    parameter int W     = 8,
    parameter int WINIT = 128,
    parameter int LR    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_IN-1:0]           x,
    input  logic [W-1:0]              bias,
    input  logic [W-1:0]              threshold,
    input  logic                      wr_en,
    input  logic [$clog2(N_IN)-1:0]   wr_addr,
    input  logic [W-1:0]              wr_data,
`ifdef PERCEPTRON_TRAIN_EN
    input  logic                      target,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      class_out,
    output logic [W-1:0]              sum_out
);

    localparam int AW = $clog2(N_IN);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        COMPARE,
`ifdef PERCEPTRON_TRAIN_EN
        UPDATE,
`endif
        DONE
    } state_t;

    state_t          state_q;
    logic [N_IN-1:0] x_q;
    logic [W-1:0]    bias_q;
    logic [W-1:0]    thr_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_d;
    logic [AW-1:0]   idx_q;
    logic            result_q;
    logic            result_d;
    logic            done_q;
    logic            class_q;
    logic [W-1:0]    sum_q;
    logic [W-1:0]    weights_q [N_IN];
    logic [W:0]      accSum;
    logic [W:0]      biasedSum;
    logic            wrHit;
    logic            lastIdx;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign class_out = class_q;
    assign sum_out   = sum_q;

    // Any carry out of the W-bit accumulator clamps it to all-ones.
    assign accSum    = {1'b0, acc_q} + (x_q[idx_q] ? {1'b0, weights_q[idx_q]} : {(W+1){1'b0}});
    assign acc_d     = accSum[W] ? {W{1'b1}} : accSum[W-1:0];
    assign biasedSum = {1'b0, acc_q} + {1'b0, bias_q};
    assign result_d  = (biasedSum > {1'b0, thr_q});
    assign wrHit     = wr_en && ({1'b0, wr_addr} < (AW+1)'(N_IN));
    assign lastIdx   = (idx_q == AW'(N_IN - 1));

`ifdef PERCEPTRON_TRAIN_EN
    localparam logic [W:0] LR1 = (W+1)'(LR);

    logic            target_q;
    logic [W-1:0]    wInc [N_IN];
    logic [W-1:0]    wDec [N_IN];
    logic [W:0]      wUp  [N_IN];

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            wUp[i]  = {1'b0, weights_q[i]} + LR1;
            wInc[i] = wUp[i][W] ? {W{1'b1}} : wUp[i][W-1:0];
            wDec[i] = ({1'b0, weights_q[i]} < LR1) ? {W{1'b0}} : (weights_q[i] - LR1[W-1:0]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            bias_q   <= '0;
            thr_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= 1'b0;
            done_q   <= 1'b0;
            class_q  <= 1'b0;
            sum_q    <= '0;
`ifdef PERCEPTRON_TRAIN_EN
            target_q <= 1'b0;
`endif
            for (int i = 0; i < N_IN; i++) begin
                weights_q[i] <= W'(WINIT);
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // The write lands on the same edge as the latch, so the pass reads it from ACCUM onward.
                    if (wrHit) begin
                        weights_q[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        x_q     <= x;
                        bias_q  <= bias;
                        thr_q   <= threshold;
`ifdef PERCEPTRON_TRAIN_EN
                        target_q <= target;
`endif
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + AW'(1);
                    if (lastIdx) begin
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    result_q <= result_d;
`ifdef PERCEPTRON_TRAIN_EN
                    state_q  <= (result_d != target_q) ? UPDATE : DONE;
`else
                    state_q  <= DONE;
`endif
                end
`ifdef PERCEPTRON_TRAIN_EN
                UPDATE: begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (x_q[i]) begin
                            weights_q[i] <= target_q ? wInc[i] : wDec[i];
                        end
                    end
                    state_q <= DONE;
                end
`endif
                DONE: begin
                    class_q <= result_q;
                    sum_q   <= acc_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
